// File: rtl/ga_pkg.sv
// Shared types and default widths for the active-node pool manager and the no_ativo slots.
package ga_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUSCA    = 3'd1,
    ESCREVE  = 3'd2,
    SAIDA    = 3'd3,
    DESATIVA = 3'd4,
    ESPERA   = 3'd5
  } ga_estado_t;

  localparam int GA_NUM_NA          = 8;
  localparam int GA_ADR_WIDTH       = 5;
  localparam int GA_DISTANCIA_WIDTH = 5;
  localparam int GA_CRITERIO_WIDTH  = 5;
  localparam int GA_CUSTO_WIDTH     = 4;
  localparam int GA_DESC_WIDTH      = 8;

endpackage

// File: rtl/codificador_prioridade.sv
// Lowest-index priority encoder: one-hot of the lowest set bit, its index, and any-bit.
module codificador_prioridade #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_in,
  output logic [N-1:0]         onehot_out,
  output logic [$clog2(N)-1:0] idx_out,
  output logic                 any_out
);

  localparam int IW = $clog2(N);
  localparam logic [N-1:0] UM = N'(1);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_out = req_in & (~req_in + UM);
  assign any_out    = |req_in;

  always_comb begin
    idx_out = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_in[i]) idx_out = IW'(i);
    end
  end

endmodule

// File: rtl/gerenciador_ativos.sv
// Active-node pool manager: merges/allocates node updates into no_ativo slots and pops approved nodes.
module gerenciador_ativos
  import ga_pkg::*;
#(
  parameter int NUM_NA          = GA_NUM_NA,
  parameter int ADR_WIDTH       = GA_ADR_WIDTH,
  parameter int DISTANCIA_WIDTH = GA_DISTANCIA_WIDTH,
  parameter int CRITERIO_WIDTH  = GA_CRITERIO_WIDTH,
  parameter int CUSTO_WIDTH     = GA_CUSTO_WIDTH,
  parameter int DESC_WIDTH      = GA_DESC_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid_in,
  output logic                              req_ready_out,
  input  logic [ADR_WIDTH-1:0]              req_endereco_in,
  input  logic [ADR_WIDTH-1:0]              req_anterior_in,
  input  logic [DISTANCIA_WIDTH-1:0]        req_distancia_in,
  input  logic [CUSTO_WIDTH-1:0]            req_menor_vizinho_in,
  input  logic [NUM_NA-1:0]                 na_ativo_in,
  input  logic [NUM_NA-1:0]                 na_aprovado_in,
  input  logic [NUM_NA*ADR_WIDTH-1:0]       na_endereco_in,
  input  logic [NUM_NA*ADR_WIDTH-1:0]       na_anterior_in,
  input  logic [NUM_NA*DISTANCIA_WIDTH-1:0] na_distancia_in,
  output logic [NUM_NA-1:0]                 ga_habilitar_out,
  output logic                              ga_atualizar_out,
  output logic                              ga_desativar_out,
  output logic [ADR_WIDTH-1:0]              ga_endereco_out,
  output logic [ADR_WIDTH-1:0]              ga_anterior_out,
  output logic [DISTANCIA_WIDTH-1:0]        ga_distancia_out,
  output logic [CUSTO_WIDTH-1:0]            ga_menor_vizinho_out,
  output logic                              sel_valid_out,
  input  logic                              sel_ready_in,
  output logic [ADR_WIDTH-1:0]              sel_endereco_out,
  output logic [ADR_WIDTH-1:0]              sel_anterior_out,
  output logic [DISTANCIA_WIDTH-1:0]        sel_distancia_out,
  output logic                              ga_cheio_out,
  output logic                              ga_vazio_out,
  output logic                              ga_overflow_out,
  output logic [DESC_WIDTH-1:0]             ga_descartados_out
);

  localparam int IW = $clog2(NUM_NA);
  // The criterion travels through no_ativo untouched; it never reaches this block.
  localparam int CRITERIO_W_UNUSED = CRITERIO_WIDTH;

  function automatic logic [DESC_WIDTH-1:0] sat_inc(input logic [DESC_WIDTH-1:0] v);
    return (&v) ? v : v + DESC_WIDTH'(1);
  endfunction

  logic [ADR_WIDTH-1:0]       slot_end  [NUM_NA];
  logic [ADR_WIDTH-1:0]       slot_ant  [NUM_NA];
  logic [DISTANCIA_WIDTH-1:0] slot_dist [NUM_NA];

  ga_estado_t                 state_q, state_d;
  logic [ADR_WIDTH-1:0]       req_end_q, req_end_d, req_ant_q, req_ant_d;
  logic [DISTANCIA_WIDTH-1:0] req_dist_q, req_dist_d;
  logic [CUSTO_WIDTH-1:0]     req_viz_q, req_viz_d;
  logic [NUM_NA-1:0]          slot_q, slot_d, hab_q, hab_d;
  logic                       atual_q, atual_d, desat_q, desat_d;
  logic [ADR_WIDTH-1:0]       bc_end_q, bc_end_d, bc_ant_q, bc_ant_d;
  logic [DISTANCIA_WIDTH-1:0] bc_dist_q, bc_dist_d;
  logic [CUSTO_WIDTH-1:0]     bc_viz_q, bc_viz_d;
  logic                       sel_valid_q, sel_valid_d;
  logic [ADR_WIDTH-1:0]       sel_end_q, sel_end_d, sel_ant_q, sel_ant_d;
  logic [DISTANCIA_WIDTH-1:0] sel_dist_q, sel_dist_d;
  logic                       ovf_q, ovf_d;
  logic [DESC_WIDTH-1:0]      desc_q, desc_d;

  logic [NUM_NA-1:0] hit_vec, livre_vec, aprov_vec;
  logic [NUM_NA-1:0] hit_oh, livre_oh, aprov_oh;
  logic [IW-1:0]     hit_idx, livre_idx_unused, aprov_idx;
  logic              hit_any, livre_any, aprov_any;

  for (genvar i = 0; i < NUM_NA; i++) begin : g_slot
    assign slot_end[i]  = na_endereco_in[i*ADR_WIDTH +: ADR_WIDTH];
    assign slot_ant[i]  = na_anterior_in[i*ADR_WIDTH +: ADR_WIDTH];
    assign slot_dist[i] = na_distancia_in[i*DISTANCIA_WIDTH +: DISTANCIA_WIDTH];
    assign hit_vec[i]   = na_ativo_in[i] && (slot_end[i] == req_end_q);
  end

  assign livre_vec = ~na_ativo_in;
  assign aprov_vec = na_aprovado_in & na_ativo_in;

  codificador_prioridade #(.N(NUM_NA)) u_cp_hit (
    .req_in(hit_vec), .onehot_out(hit_oh), .idx_out(hit_idx), .any_out(hit_any)
  );
  codificador_prioridade #(.N(NUM_NA)) u_cp_livre (
    .req_in(livre_vec), .onehot_out(livre_oh), .idx_out(livre_idx_unused), .any_out(livre_any)
  );
  codificador_prioridade #(.N(NUM_NA)) u_cp_aprov (
    .req_in(aprov_vec), .onehot_out(aprov_oh), .idx_out(aprov_idx), .any_out(aprov_any)
  );

  always_comb begin
    state_d     = state_q;
    req_end_d   = req_end_q;
    req_ant_d   = req_ant_q;
    req_dist_d  = req_dist_q;
    req_viz_d   = req_viz_q;
    slot_d      = slot_q;
    hab_d       = '0;
    atual_d     = 1'b0;
    desat_d     = 1'b0;
    bc_end_d    = bc_end_q;
    bc_ant_d    = bc_ant_q;
    bc_dist_d   = bc_dist_q;
    bc_viz_d    = bc_viz_q;
    sel_valid_d = sel_valid_q;
    sel_end_d   = sel_end_q;
    sel_ant_d   = sel_ant_q;
    sel_dist_d  = sel_dist_q;
    ovf_d       = ovf_q;
    desc_d      = desc_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_in) begin
          req_end_d  = req_endereco_in;
          req_ant_d  = req_anterior_in;
          req_dist_d = req_distancia_in;
          req_viz_d  = req_menor_vizinho_in;
          state_d    = BUSCA;
        end else if (aprov_any) begin
          slot_d      = aprov_oh;
          sel_valid_d = 1'b1;
          sel_end_d   = slot_end[aprov_idx];
          sel_ant_d   = slot_ant[aprov_idx];
          sel_dist_d  = slot_dist[aprov_idx];
          state_d     = SAIDA;
        end
      end
      BUSCA: begin
        // Commands are registered, so the write is set up here to appear during ESCREVE.
        if (hit_any && (req_dist_q < slot_dist[hit_idx])) begin
          hab_d   = hit_oh;
          atual_d = 1'b1;
          state_d = ESCREVE;
        end else if (hit_any) begin
          desc_d  = sat_inc(desc_q);
          state_d = IDLE;
        end else if (livre_any) begin
          hab_d   = livre_oh;
          atual_d = 1'b1;
          state_d = ESCREVE;
        end else begin
          ovf_d   = 1'b1;
          desc_d  = sat_inc(desc_q);
          state_d = IDLE;
        end
        if (atual_d) begin
          bc_end_d  = req_end_q;
          bc_ant_d  = req_ant_q;
          bc_dist_d = req_dist_q;
          bc_viz_d  = req_viz_q;
        end
      end
      ESCREVE:  state_d = ESPERA;
      SAIDA: begin
        if (sel_ready_in) begin
          sel_valid_d = 1'b0;
          desat_d     = 1'b1;
          hab_d       = slot_q;
          state_d     = DESATIVA;
        end
      end
      DESATIVA: state_d = ESPERA;
      ESPERA:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_end_q   <= '0;
      req_ant_q   <= '0;
      req_dist_q  <= '0;
      req_viz_q   <= '0;
      slot_q      <= '0;
      hab_q       <= '0;
      atual_q     <= 1'b0;
      desat_q     <= 1'b0;
      bc_end_q    <= '0;
      bc_ant_q    <= '0;
      bc_dist_q   <= '0;
      bc_viz_q    <= '0;
      sel_valid_q <= 1'b0;
      sel_end_q   <= '0;
      sel_ant_q   <= '0;
      sel_dist_q  <= '0;
      ovf_q       <= 1'b0;
      desc_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_end_q   <= req_end_d;
      req_ant_q   <= req_ant_d;
      req_dist_q  <= req_dist_d;
      req_viz_q   <= req_viz_d;
      slot_q      <= slot_d;
      hab_q       <= hab_d;
      atual_q     <= atual_d;
      desat_q     <= desat_d;
      bc_end_q    <= bc_end_d;
      bc_ant_q    <= bc_ant_d;
      bc_dist_q   <= bc_dist_d;
      bc_viz_q    <= bc_viz_d;
      sel_valid_q <= sel_valid_d;
      sel_end_q   <= sel_end_d;
      sel_ant_q   <= sel_ant_d;
      sel_dist_q  <= sel_dist_d;
      ovf_q       <= ovf_d;
      desc_q      <= desc_d;
    end
  end

  assign req_ready_out        = (state_q == IDLE);
  assign ga_habilitar_out     = hab_q;
  assign ga_atualizar_out     = atual_q;
  assign ga_desativar_out     = desat_q;
  assign ga_endereco_out      = bc_end_q;
  assign ga_anterior_out      = bc_ant_q;
  assign ga_distancia_out     = bc_dist_q;
  assign ga_menor_vizinho_out = bc_viz_q;
  assign sel_valid_out        = sel_valid_q;
  assign sel_endereco_out     = sel_end_q;
  assign sel_anterior_out     = sel_ant_q;
  assign sel_distancia_out    = sel_dist_q;
  assign ga_cheio_out         = &na_ativo_in;
  assign ga_vazio_out         = ~|na_ativo_in;
  assign ga_overflow_out      = ovf_q;
  assign ga_descartados_out   = desc_q;

endmodule

// File: tb/tb_gerenciador_ativos.sv
// Bench for gerenciador_ativos: behavioural pool of slots plus a rule-level model of merge/allocate/pop.
module tb_gerenciador_ativos;

  localparam int NA = 8;
  localparam int AW = 5;
  localparam int DW = 5;
  localparam int VW = 4;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst;
  logic req_valid_in, req_ready_out;
  logic [AW-1:0] req_endereco_in, req_anterior_in;
  logic [DW-1:0] req_distancia_in;
  logic [VW-1:0] req_menor_vizinho_in;
  logic [NA-1:0] na_ativo_in, na_aprovado_in;
  logic [NA*AW-1:0] na_endereco_in, na_anterior_in;
  logic [NA*DW-1:0] na_distancia_in;
  logic [NA-1:0] ga_habilitar_out;
  logic ga_atualizar_out, ga_desativar_out;
  logic [AW-1:0] ga_endereco_out, ga_anterior_out;
  logic [DW-1:0] ga_distancia_out;
  logic [VW-1:0] ga_menor_vizinho_out;
  logic sel_valid_out, sel_ready_in;
  logic [AW-1:0] sel_endereco_out, sel_anterior_out;
  logic [DW-1:0] sel_distancia_out;
  logic ga_cheio_out, ga_vazio_out, ga_overflow_out;
  logic [SW-1:0] ga_descartados_out;

  int n_checks = 0;
  int n_err = 0;
  int exp_desc = 0;
  logic exp_ovf = 1'b0;

  // Behavioural pool: slot status/data change only on the broadcast commands.
  bit          p_act  [NA];
  bit          p_apr  [NA];
  bit [AW-1:0] p_end  [NA];
  bit [AW-1:0] p_ant  [NA];
  bit [DW-1:0] p_dist [NA];

  gerenciador_ativos dut (
    .clk(clk), .rst(rst),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_endereco_in(req_endereco_in), .req_anterior_in(req_anterior_in),
    .req_distancia_in(req_distancia_in), .req_menor_vizinho_in(req_menor_vizinho_in),
    .na_ativo_in(na_ativo_in), .na_aprovado_in(na_aprovado_in),
    .na_endereco_in(na_endereco_in), .na_anterior_in(na_anterior_in),
    .na_distancia_in(na_distancia_in),
    .ga_habilitar_out(ga_habilitar_out), .ga_atualizar_out(ga_atualizar_out),
    .ga_desativar_out(ga_desativar_out),
    .ga_endereco_out(ga_endereco_out), .ga_anterior_out(ga_anterior_out),
    .ga_distancia_out(ga_distancia_out), .ga_menor_vizinho_out(ga_menor_vizinho_out),
    .sel_valid_out(sel_valid_out), .sel_ready_in(sel_ready_in),
    .sel_endereco_out(sel_endereco_out), .sel_anterior_out(sel_anterior_out),
    .sel_distancia_out(sel_distancia_out),
    .ga_cheio_out(ga_cheio_out), .ga_vazio_out(ga_vazio_out),
    .ga_overflow_out(ga_overflow_out), .ga_descartados_out(ga_descartados_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    na_ativo_in     = '0;
    na_aprovado_in  = '0;
    na_endereco_in  = '0;
    na_anterior_in  = '0;
    na_distancia_in = '0;
    for (int i = 0; i < NA; i++) begin
      na_ativo_in[i]               = p_act[i];
      na_aprovado_in[i]            = p_apr[i];
      na_endereco_in[i*AW +: AW]   = p_end[i];
      na_anterior_in[i*AW +: AW]   = p_ant[i];
      na_distancia_in[i*DW +: DW]  = p_dist[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NA; i++) begin
      if (ga_atualizar_out && ga_habilitar_out[i]) begin
        p_act[i]  <= 1'b1;
        p_end[i]  <= ga_endereco_out;
        p_ant[i]  <= ga_anterior_out;
        p_dist[i] <= ga_distancia_out;
      end
      if (ga_desativar_out && ga_habilitar_out[i]) p_act[i] <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rule model: kind 0 = write slot, 1 = dropped (not better), 2 = dropped (pool full).
  function automatic void predict(input logic [AW-1:0] e, input logic [DW-1:0] d,
                                  output int kind, output int slot);
    bit found = 0;
    kind = 2;
    slot = -1;
    for (int i = 0; i < NA; i++) begin
      if (!found && p_act[i] && p_end[i] == e) begin
        found = 1;
        slot  = i;
        kind  = (d < p_dist[i]) ? 0 : 1;
      end
    end
    for (int i = 0; i < NA; i++) begin
      if (!found && !p_act[i]) begin
        found = 1;
        slot  = i;
        kind  = 0;
      end
    end
  endfunction

  task automatic send_req(input logic [AW-1:0] e, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [VW-1:0] v);
    int kind, slot, n_at, n_des, k_at, k_rdy;
    logic [NA-1:0] hab_s;
    logic [AW-1:0] e_s, a_s;
    logic [DW-1:0] d_s;
    logic [VW-1:0] v_s;
    predict(e, d, kind, slot);
    chk("req_ready_before", {31'd0, req_ready_out}, 32'd1);
    req_valid_in = 1'b1;
    req_endereco_in = e;
    req_anterior_in = a;
    req_distancia_in = d;
    req_menor_vizinho_in = v;
    @(posedge clk); #1;
    req_valid_in = 1'b0;
    n_at = 0; n_des = 0; k_at = -1; k_rdy = -1;
    hab_s = '0; e_s = '0; a_s = '0; d_s = '0; v_s = '0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (ga_atualizar_out) begin
        n_at++;
        if (k_at < 0) begin
          k_at = k; hab_s = ga_habilitar_out;
          e_s = ga_endereco_out; a_s = ga_anterior_out;
          d_s = ga_distancia_out; v_s = ga_menor_vizinho_out;
        end
      end
      if (ga_desativar_out) n_des++;
      if (k_rdy < 0 && req_ready_out) k_rdy = k;
    end
    if (kind != 0 && exp_desc < 255) exp_desc++;
    if (kind == 2) exp_ovf = 1'b1;
    chk("atual_count", n_at, (kind == 0) ? 1 : 0);
    chk("no_desativar", n_des, 0);
    if (kind == 0) begin
      chk("atual_cycle", k_at, 1);
      chk("habilitar", {24'd0, hab_s}, 32'd1 << slot);
      chk("bc_endereco", {27'd0, e_s}, {27'd0, e});
      chk("bc_anterior", {27'd0, a_s}, {27'd0, a});
      chk("bc_distancia", {27'd0, d_s}, {27'd0, d});
      chk("bc_vizinho", {28'd0, v_s}, {28'd0, v});
      chk("ready_after_write", k_rdy, 3);
    end else begin
      chk("ready_after_drop", k_rdy, 1);
    end
    chk("descartados", {24'd0, ga_descartados_out}, exp_desc);
    chk("overflow", {31'd0, ga_overflow_out}, {31'd0, exp_ovf});
  endtask

  task automatic do_pop(input int hold);
    int slot = -1;
    int t = 0;
    bit stable = 1;
    for (int i = NA - 1; i >= 0; i--) if (p_act[i] && p_apr[i]) slot = i;
    if (slot < 0) slot = 0;
    while (!sel_valid_out && t < 10) begin @(posedge clk); #1; t++; end
    chk("sel_valid_up", {31'd0, sel_valid_out}, 32'd1);
    chk("sel_endereco", {27'd0, sel_endereco_out}, {27'd0, p_end[slot]});
    chk("sel_anterior", {27'd0, sel_anterior_out}, {27'd0, p_ant[slot]});
    chk("sel_distancia", {27'd0, sel_distancia_out}, {27'd0, p_dist[slot]});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (!sel_valid_out || ga_desativar_out || sel_endereco_out != p_end[slot] ||
          sel_distancia_out != p_dist[slot]) stable = 0;
    end
    chk("sel_stable", {31'd0, stable}, 32'd1);
    sel_ready_in = 1'b1;
    @(posedge clk); #1;
    sel_ready_in = 1'b0;
    p_apr[slot] = 1'b0;
    chk("desativar_on", {31'd0, ga_desativar_out}, 32'd1);
    chk("desativar_hab", {24'd0, ga_habilitar_out}, 32'd1 << slot);
    chk("sel_valid_down", {31'd0, sel_valid_out}, 32'd0);
    @(posedge clk); #1;
    chk("desativar_off", {31'd0, ga_desativar_out}, 32'd0);
    chk("hab_idle", {24'd0, ga_habilitar_out}, 32'd0);
    chk("ready_espera", {31'd0, req_ready_out}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_pop", {31'd0, req_ready_out}, 32'd1);
  endtask

  initial begin
    int j, n_des;
    rst = 1'b1;
    req_valid_in = 1'b0;
    req_endereco_in = '0;
    req_anterior_in = '0;
    req_distancia_in = '0;
    req_menor_vizinho_in = '0;
    sel_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hab", {24'd0, ga_habilitar_out}, 32'd0);
    chk("rst_atual", {31'd0, ga_atualizar_out}, 32'd0);
    chk("rst_sel_valid", {31'd0, sel_valid_out}, 32'd0);
    chk("rst_desc", {24'd0, ga_descartados_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, req_ready_out}, 32'd1);
    chk("vazio", {31'd0, ga_vazio_out}, 32'd1);
    chk("cheio_empty", {31'd0, ga_cheio_out}, 32'd0);

    // Allocation, merge with a better distance, drop of a worse one.
    send_req(5'd2, 5'd1, 5'd20, 4'd5);
    send_req(5'd2, 5'd3, 5'd10, 4'd2);
    send_req(5'd2, 5'd4, 5'd15, 4'd1);

    // Fill the pool, then overflow and a sticky-flag check.
    for (int i = 1; i < NA; i++) send_req(AW'(10 + i), AW'(i), DW'(i), VW'(i));
    chk("cheio_full", {31'd0, ga_cheio_out}, 32'd1);
    send_req(5'd9, 5'd0, 5'd1, 4'd0);
    send_req(5'd2, 5'd0, 5'd31, 4'd0);

    // Two approved slots: lowest pops first, held under backpressure.
    p_apr[3] = 1'b1;
    p_apr[5] = 1'b1;
    do_pop(4);
    do_pop(0);

    // Request and approved slot in the same cycle: the request wins.
    p_apr[0] = 1'b1;
    send_req(5'd7, 5'd6, 5'd9, 4'd3);
    chk("pop_after_req", {31'd0, sel_valid_out}, 32'd1);
    do_pop(1);

    // Reset while a write command is on the bus.
    req_valid_in = 1'b1;
    req_endereco_in = 5'd21;
    req_distancia_in = 5'd4;
    @(posedge clk); #1;
    req_valid_in = 1'b0;
    @(posedge clk); #1;
    chk("rstA_atual_before", {31'd0, ga_atualizar_out}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstA_atual", {31'd0, ga_atualizar_out}, 32'd0);
    chk("rstA_hab", {24'd0, ga_habilitar_out}, 32'd0);
    chk("rstA_bc_end", {27'd0, ga_endereco_out}, 32'd0);
    chk("rstA_desc", {24'd0, ga_descartados_out}, 32'd0);
    chk("rstA_ovf", {31'd0, ga_overflow_out}, 32'd0);
    exp_desc = 0;
    exp_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstA_ready", {31'd0, req_ready_out}, 32'd1);
    chk("rstA_not_written", {31'd0, p_act[0]}, 32'd0);

    // Reset while a pop waits for the downstream stage.
    p_apr[1] = 1'b1;
    j = 0;
    while (!sel_valid_out && j < 10) begin @(posedge clk); #1; j++; end
    chk("rstB_sel_valid_before", {31'd0, sel_valid_out}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    p_apr[1] = 1'b0;
    chk("rstB_sel_valid", {31'd0, sel_valid_out}, 32'd0);
    chk("rstB_sel_end", {27'd0, sel_endereco_out}, 32'd0);
    chk("rstB_sel_dist", {27'd0, sel_distancia_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_des = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ga_desativar_out) n_des++;
    end
    chk("rstB_no_desativar", n_des, 0);
    chk("rstB_ready", {31'd0, req_ready_out}, 32'd1);

    // Randomised traffic against the rule model.
    for (int it = 0; it < 90; it++) begin
      j = int'($urandom_range(0, NA - 1));
      if ($urandom_range(0, 3) == 0 && p_act[j]) begin
        p_apr[j] = 1'b1;
        do_pop(int'($urandom_range(0, 2)));
      end else begin
        send_req(AW'($urandom_range(0, 11)), AW'($urandom_range(0, 31)),
                 DW'($urandom_range(0, 31)), VW'($urandom_range(0, 15)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
